// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes, drain defaults and
// register constants. Optional feature macro used by the top: PERF_CNT_EN.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDrain   = 2'd1,
        StSysWait = 2'd2,
        StResume  = 2'd3
    } state_e;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    // Wide enough for the full legal DRAIN_CYCLES range of 1..7.
    localparam int unsigned DRAIN_CNT_W      = 3;
    localparam logic [4:0]  REG_ZERO         = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller. The master side is the datapath and
// syscall service model; the slave side is the controller itself.
interface pipeline_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_sys;
    logic       id_jump;
    logic       id_jr;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       ex_br_taken;
    logic       sys_ack;

    logic       pc_hold;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       sys_req;
    logic       sys_issue;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_sys, id_jump, id_jr,
        output ex_memread, ex_rt, ex_br_taken, sys_ack,
        input  pc_hold, ifid_flush, idex_bubble, sys_req, sys_issue
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_sys, id_jump, id_jr,
        input  ex_memread, ex_rt, ex_br_taken, sys_ack,
        output pc_hold, ifid_flush, idex_bubble, sys_req, sys_issue
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the load in EX and the source operands in ID.
module pipeline_hazard_ctrl_load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs && (id_rs == ex_rt);
    assign rt_match = id_uses_rt && (id_rt == ex_rt);

    // A load into $0 never produces a value anyone can depend on.
    assign hazard = ex_memread && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, branch/jump flushes and syscall
// drain with a req/ack service handshake. Define PERF_CNT_EN to build the stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_b,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic pc_hold;
    logic ifid_flush;
    logic idex_bubble;
    logic sys_req;
    logic sys_issue;

    pipeline_hazard_ctrl_load_use_detect u_load_use_detect (
        .id_rs      (hz.id_rs),
        .id_rt      (hz.id_rt),
        .id_uses_rs (hz.id_uses_rs),
        .id_uses_rt (hz.id_uses_rt),
        .ex_memread (hz.ex_memread),
        .ex_rt      (hz.ex_rt),
        .hazard     (load_use)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_hold     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        sys_req     = 1'b0;
        sys_issue   = 1'b0;

        unique case (state_q)
            StRun: begin
                // A taken branch squashes everything younger, including a syscall in ID.
                if (hz.ex_br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_hold     = 1'b1;
                    idex_bubble = 1'b1;
                end else if (hz.id_sys) begin
                    pc_hold     = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = DRAIN_LOAD;
                    state_d     = (DRAIN_LOAD == '0) ? StSysWait : StDrain;
                end else if (hz.id_jump || hz.id_jr) begin
                    ifid_flush = 1'b1;
                end
            end
            StDrain: begin
                pc_hold     = 1'b1;
                idex_bubble = 1'b1;
                if (cnt_q <= DRAIN_CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = StSysWait;
                end else begin
                    cnt_d = cnt_q - DRAIN_CNT_W'(1);
                end
            end
            StSysWait: begin
                pc_hold     = 1'b1;
                idex_bubble = 1'b1;
                sys_req     = 1'b1;
                if (hz.sys_ack) begin
                    state_d = StResume;
                end
            end
            StResume: begin
                sys_issue = 1'b1;
                state_d   = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        // Hold every output low while reset is asserted, even with hazards on the inputs.
        if (!rst_b) begin
            pc_hold     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            sys_req     = 1'b0;
            sys_issue   = 1'b0;
        end
    end

    assign hz.pc_hold     = pc_hold;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.sys_req     = sys_req;
    assign hz.sys_issue   = sys_issue;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_hold && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
